// File: rtl/morse_pkg.sv
// Shared Morse definitions: FSM states, timing constants and the ITU lookup table.
// The lookup returns {len[2:0], pat[4:0]}; element i is pat[4-i] with 1 = dash.
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        ELEM_GAP,
        CHAR_GAP,
        WORD_GAP
    } morse_state_t;

    localparam logic [5:0] CODE_SPACE     = 6'd36;
    localparam logic [5:0] CODE_MAX       = 6'd36;
    localparam logic [2:0] DOT_UNITS      = 3'd1;
    localparam logic [2:0] DASH_UNITS     = 3'd3;
    localparam logic [2:0] ELEM_GAP_UNITS = 3'd1;
    localparam logic [2:0] CHAR_GAP_UNITS = 3'd3;
    localparam logic [2:0] WORD_GAP_UNITS = 3'd7;

    function automatic logic [7:0] morse_lut(input logic [5:0] code);
        logic [7:0] r;
        case (code)
            6'd0:  r = {3'd2, 5'b01000};  // A .-
            6'd1:  r = {3'd4, 5'b10000};  // B -...
            6'd2:  r = {3'd4, 5'b10100};  // C -.-.
            6'd3:  r = {3'd3, 5'b10000};  // D -..
            6'd4:  r = {3'd1, 5'b00000};  // E .
            6'd5:  r = {3'd4, 5'b00100};  // F ..-.
            6'd6:  r = {3'd3, 5'b11000};  // G --.
            6'd7:  r = {3'd4, 5'b00000};  // H ....
            6'd8:  r = {3'd2, 5'b00000};  // I ..
            6'd9:  r = {3'd4, 5'b01110};  // J .---
            6'd10: r = {3'd3, 5'b10100};  // K -.-
            6'd11: r = {3'd4, 5'b01000};  // L .-..
            6'd12: r = {3'd2, 5'b11000};  // M --
            6'd13: r = {3'd2, 5'b10000};  // N -.
            6'd14: r = {3'd3, 5'b11100};  // O ---
            6'd15: r = {3'd4, 5'b01100};  // P .--.
            6'd16: r = {3'd4, 5'b11010};  // Q --.-
            6'd17: r = {3'd3, 5'b01000};  // R .-.
            6'd18: r = {3'd3, 5'b00000};  // S ...
            6'd19: r = {3'd1, 5'b10000};  // T -
            6'd20: r = {3'd3, 5'b00100};  // U ..-
            6'd21: r = {3'd4, 5'b00010};  // V ...-
            6'd22: r = {3'd3, 5'b01100};  // W .--
            6'd23: r = {3'd4, 5'b10010};  // X -..-
            6'd24: r = {3'd4, 5'b10110};  // Y -.--
            6'd25: r = {3'd4, 5'b11000};  // Z --..
            6'd26: r = {3'd5, 5'b11111};  // 0
            6'd27: r = {3'd5, 5'b01111};  // 1
            6'd28: r = {3'd5, 5'b00111};  // 2
            6'd29: r = {3'd5, 5'b00011};  // 3
            6'd30: r = {3'd5, 5'b00001};  // 4
            6'd31: r = {3'd5, 5'b00000};  // 5
            6'd32: r = {3'd5, 5'b10000};  // 6
            6'd33: r = {3'd5, 5'b11000};  // 7
            6'd34: r = {3'd5, 5'b11100};  // 8
            6'd35: r = {3'd5, 5'b11110};  // 9
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/morse_encoder_if.sv
// Character handshake between a code source (master) and the Morse encoder (slave).
interface morse_encoder_if;
    logic       char_valid;
    logic [5:0] char_code;
    logic       char_ready;

    modport master (output char_valid, output char_code, input char_ready);
    modport slave  (input char_valid, input char_code, output char_ready);
endinterface

// File: rtl/morse_unit_timer.sv
// Morse time-unit down-counter: restart reloads it, unit_tick marks the last cycle of each unit.
module morse_unit_timer #(
    parameter int unsigned UNIT_CYCLES = 1200000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic unit_tick
);
    localparam int unsigned CW = $clog2(UNIT_CYCLES);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || cnt == '0) begin
            cnt <= CW'(UNIT_CYCLES - 1);
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign unit_tick = (cnt == '0);
endmodule

// File: rtl/morse_encoder.sv
// Morse transmitter: accepts one character code per handshake and keys out ITU timing
// with a gated sidetone; key_out is registered from the next state so it aligns with MARK.
module morse_encoder
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 1200000,
    parameter int unsigned TONE_HALF   = 7500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    morse_encoder_if.slave        bus,
    output logic                  key_out,
    output logic                  tone_out,
    output logic                  busy,
    output logic                  invalid_code
);
    localparam int unsigned TW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

    morse_state_t state, state_next;
    logic [2:0]   elem, elem_next;
    logic [2:0]   units, units_next;
    logic [2:0]   cur_len, len_next;
    logic [4:0]   cur_pat, pat_next;
    logic         inv_next;
    logic [7:0]   lut;
    logic         unit_tick;
    logic [TW-1:0] tone_cnt;
    logic         sq;

    assign lut = morse_lut(bus.char_code);

    morse_unit_timer #(.UNIT_CYCLES(UNIT_CYCLES)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart   (state_next != state),
        .unit_tick (unit_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            elem         <= '0;
            units        <= '0;
            cur_len      <= '0;
            cur_pat      <= '0;
            key_out      <= 1'b0;
            invalid_code <= 1'b0;
        end else begin
            state        <= state_next;
            elem         <= elem_next;
            units        <= units_next;
            cur_len      <= len_next;
            cur_pat      <= pat_next;
            key_out      <= (state_next == MARK);
            invalid_code <= inv_next;
        end
    end

    // The current element is always cur_pat[4]; the pattern shifts left per element.
    always_comb begin
        state_next = state;
        elem_next  = elem;
        units_next = units;
        len_next   = cur_len;
        pat_next   = cur_pat;
        inv_next   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.char_valid) begin
                    if (bus.char_code == CODE_SPACE) begin
                        state_next = WORD_GAP;
                        units_next = WORD_GAP_UNITS - 3'd1;
                    end else if (bus.char_code > CODE_MAX) begin
                        inv_next = 1'b1;
                    end else begin
                        state_next = MARK;
                        elem_next  = '0;
                        len_next   = lut[7:5];
                        pat_next   = lut[4:0];
                        units_next = lut[4] ? DASH_UNITS - 3'd1 : DOT_UNITS - 3'd1;
                    end
                end
            end
            MARK: begin
                if (unit_tick) begin
                    if (units != '0) begin
                        units_next = units - 3'd1;
                    end else if (elem == cur_len - 3'd1) begin
                        state_next = CHAR_GAP;
                        units_next = CHAR_GAP_UNITS - 3'd1;
                    end else begin
                        state_next = ELEM_GAP;
                        units_next = ELEM_GAP_UNITS - 3'd1;
                    end
                end
            end
            ELEM_GAP: begin
                if (unit_tick) begin
                    if (units != '0) begin
                        units_next = units - 3'd1;
                    end else begin
                        state_next = MARK;
                        elem_next  = elem + 3'd1;
                        pat_next   = {cur_pat[3:0], 1'b0};
                        units_next = cur_pat[3] ? DASH_UNITS - 3'd1 : DOT_UNITS - 3'd1;
                    end
                end
            end
            CHAR_GAP, WORD_GAP: begin
                if (unit_tick) begin
                    if (units != '0) begin
                        units_next = units - 3'd1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tone_cnt <= '0;
            sq       <= 1'b0;
        end else if (!key_out) begin
            tone_cnt <= '0;
            sq       <= 1'b0;
        end else if (tone_cnt == TW'(TONE_HALF - 1)) begin
            tone_cnt <= '0;
            sq       <= ~sq;
        end else begin
            tone_cnt <= tone_cnt + 1'b1;
        end
    end

    assign tone_out       = key_out & sq;
    assign bus.char_ready = (state == IDLE);
    assign busy           = (state != IDLE);
endmodule
